// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between loader, data unit and fetch unit
// with IDLE -> ACCESS -> RESP sequencing and address legality checks.
module mem_port_arbiter #(
    parameter int MEM_BYTES  = 2048,
    parameter int INST_BYTES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ld_req,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_wdata,
    output logic        o_ld_ack,
    output logic        o_ld_err,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_ack,
    output logic        o_dm_err,
    output logic [31:0] o_dm_rdata,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic        o_if_err,
    output logic [31:0] o_if_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic [1:0]  o_owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_owner, w_grant;
    logic [31:0] r_addr, r_wdata, r_dm_rdata, r_if_rdata, w_addr, w_wdata;
    logic        r_we, r_illegal, r_last, w_we, w_illegal, w_dm_win, w_access, w_resp;

    // r_last: 1 = fetch was the last data/fetch grant, so data wins the next tie
    always_comb begin
        w_dm_win  = i_dm_req && (!i_if_req || r_last);
        w_grant   = i_ld_req ? 2'd1 : w_dm_win ? 2'd2 : i_if_req ? 2'd3 : 2'd0;
        w_addr    = i_ld_req ? i_ld_addr : w_dm_win ? i_dm_addr : i_if_addr;
        w_we      = i_ld_req || (w_dm_win && i_dm_we);
        w_wdata   = i_ld_req ? i_ld_wdata : w_dm_win ? i_dm_wdata : 32'd0;
        w_illegal = (|w_addr[1:0]) || (w_addr >= 32'(MEM_BYTES)) ||
                    (w_grant == 2'd3 && w_addr >= 32'(INST_BYTES));
        w_next    = r_state == ACCESS ? RESP :
                    (r_state == IDLE && w_grant != 2'd0) ? ACCESS : IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner    <= 2'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_illegal  <= 1'b0;
            r_last     <= 1'b1;
            r_dm_rdata <= 32'd0;
            r_if_rdata <= 32'd0;
        end else begin
            if (r_state == IDLE && w_grant != 2'd0) begin
                r_owner   <= w_grant;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_we      <= w_we;
                r_illegal <= w_illegal;
                if (!i_ld_req) r_last <= !w_dm_win;
            end
            if (r_state == ACCESS && !r_we && r_owner == 2'd2) r_dm_rdata <= r_illegal ? 32'd0 : i_mem_rdata;
            if (r_state == ACCESS && !r_we && r_owner == 2'd3) r_if_rdata <= r_illegal ? 32'd0 : i_mem_rdata;
        end
    end

    assign w_access    = r_state == ACCESS;
    assign w_resp      = r_state == RESP;
    assign o_mem_addr  = w_access ? r_addr : 32'd0;
    assign o_mem_wdata = w_access ? r_wdata : 32'd0;
    assign o_mem_we    = w_access && r_we && !r_illegal;
    assign o_busy      = r_state != IDLE;
    assign o_owner     = o_busy ? r_owner : 2'd0;
    assign o_ld_ack    = w_resp && r_owner == 2'd1;
    assign o_dm_ack    = w_resp && r_owner == 2'd2;
    assign o_if_ack    = w_resp && r_owner == 2'd3;
    assign o_ld_err    = o_ld_ack && r_illegal;
    assign o_dm_err    = o_dm_ack && r_illegal;
    assign o_if_err    = o_if_ack && r_illegal;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_if_rdata  = r_if_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions checked against a
// transaction-level memory/arbitration model.
module tb_mem_port_arbiter;
    logic        clk, rst;
    logic        ld_req, dm_req, dm_we, if_req;
    logic [31:0] ld_addr, ld_wdata, dm_addr, dm_wdata, if_addr;
    logic        ld_ack, ld_err, dm_ack, dm_err, if_ack, if_err, mem_we, busy;
    logic [31:0] dm_rdata, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;
    logic [31:0] mem [512] = '{default: 32'd0};
    logic [31:0] ref_mem [512] = '{default: 32'd0};
    logic [31:0] ref_dm, ref_if;
    int          ref_last, we_cnt = 0, n_chk = 0, n_fail = 0;

    mem_port_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_ld_req(ld_req), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
        .o_ld_ack(ld_ack), .o_ld_err(ld_err),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_ack(dm_ack), .o_dm_err(dm_err), .o_dm_rdata(dm_rdata),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ack(if_ack), .o_if_err(if_err), .o_if_rdata(if_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy), .o_owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[10:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[10:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic bad_addr(input int own, input logic [31:0] a);
        return a % 4 != 0 || a >= 2048 || (own == 3 && a >= 1024);
    endfunction

    // one isolated transaction, started at a negedge while the arbiter is idle
    task automatic do_txn(input int own, input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic bad, ak, er, wr;
        int   cyc, wc0;
        bad = bad_addr(own, a);
        wr  = own == 1 || (own == 2 && we);
        wc0 = we_cnt;
        ak  = 1'b0;
        er  = 1'b0;
        cyc = 0;
        if (own == 1) begin ld_req = 1; ld_addr = a; ld_wdata = wd; end
        if (own == 2) begin dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; end
        if (own == 3) begin if_req = 1; if_addr = a; end
        while (!ak && cyc < 8) begin
            @(negedge clk);
            cyc++;
            ak = own == 1 ? ld_ack : own == 2 ? dm_ack : if_ack;
            er = own == 1 ? ld_err : own == 2 ? dm_err : if_err;
        end
        ld_req = 0; dm_req = 0; if_req = 0;
        if (wr && !bad) ref_mem[a[10:2]] = wd;
        if (own == 2 && !we) ref_dm = bad ? 32'd0 : ref_mem[a[10:2]];
        if (own == 3) ref_if = bad ? 32'd0 : ref_mem[a[10:2]];
        if (own > 1) ref_last = own;
        chk($sformatf("latency own%0d", own), cyc, 2);
        chk($sformatf("err own%0d @%h", own, a), er, bad);
        chk("dm_rdata", dm_rdata, ref_dm);
        chk("if_rdata", if_rdata, ref_if);
        chk("write_count", we_cnt - wc0, (wr && !bad) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        int exp_own, n_ack, got;
        int ord [3];
        logic [31:0] a;
        rst = 1; ld_req = 0; dm_req = 0; if_req = 0; dm_we = 0;
        ld_addr = 0; ld_wdata = 0; dm_addr = 0; dm_wdata = 0; if_addr = 0;
        ref_dm = 0; ref_if = 0; ref_last = 3;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst owner", owner, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst acks", {ld_ack, dm_ack, if_ack, ld_err, dm_err, if_err}, 0);
        chk("rst dm_rdata", dm_rdata, 0);
        chk("rst if_rdata", if_rdata, 0);
        rst = 0;
        @(negedge clk);

        do_txn(1, 1, 32'h004, 32'hDEADBEEF);
        do_txn(3, 0, 32'h004, 0);
        chk("fetch loaded word", if_rdata, 32'hDEADBEEF);
        do_txn(2, 1, 32'h400, 32'h12345678);
        do_txn(2, 0, 32'h400, 0);
        chk("data readback", dm_rdata, 32'h12345678);

        // data and fetch contend for 12 cycles
        dm_req = 1; dm_we = 0; dm_addr = 32'h400; if_req = 1; if_addr = 32'h004;
        exp_own = ref_last == 3 ? 2 : 3;
        n_ack = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dm_ack || if_ack) begin
                chk("fair owner", owner, exp_own);
                chk("fair ack", dm_ack ? 2 : 3, exp_own);
                if (exp_own == 2) ref_dm = ref_mem[32'h400 >> 2];
                else ref_if = ref_mem[1];
                ref_last = exp_own;
                exp_own = 5 - exp_own;
                n_ack++;
            end
        end
        dm_req = 0; if_req = 0;
        chk("fair acks", n_ack, 4);
        chk("fair dm_rdata", dm_rdata, ref_dm);
        chk("fair if_rdata", if_rdata, ref_if);

        do_txn(2, 1, 32'h402, 32'h0BAD0BAD);
        do_txn(3, 0, 32'h400, 0);
        do_txn(1, 1, 32'h800, 32'h0BADF00D);
        do_txn(2, 0, 32'h400, 0);
        chk("read after errors", dm_rdata, 32'h12345678);

        // all three at once: loader first, then the data/fetch tie-break
        ld_req = 1; ld_addr = 32'h600; ld_wdata = 32'hA5A50001;
        dm_req = 1; dm_we = 0; dm_addr = 32'h404; if_req = 1; if_addr = 32'h008;
        ord[0] = 1; ord[1] = ref_last == 3 ? 2 : 3; ord[2] = 5 - ord[1];
        n_ack = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            got = ld_ack ? 1 : dm_ack ? 2 : if_ack ? 3 : 0;
            if (got != 0) begin
                chk("sim order", got, n_ack < 3 ? ord[n_ack] : 0);
                if (got == 1) ld_req = 0;
                if (got == 2) dm_req = 0;
                if (got == 3) if_req = 0;
                n_ack++;
            end
        end
        ld_req = 0; dm_req = 0; if_req = 0;
        ref_mem[32'h600 >> 2] = 32'hA5A50001;
        ref_dm = ref_mem[32'h404 >> 2];
        ref_if = ref_mem[32'h008 >> 2];
        ref_last = ord[2];
        chk("sim acks", n_ack, 3);
        chk("sim dm_rdata", dm_rdata, ref_dm);
        chk("sim if_rdata", if_rdata, ref_if);

        // reset in the middle of a data write's ACCESS cycle
        dm_req = 1; dm_we = 1; dm_addr = 32'h408; dm_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("pre-rst mem_we", mem_we, 1);
        rst = 1;
        #1;
        chk("rst mid mem_we", mem_we, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid owner", owner, 0);
        chk("rst mid mem_addr", mem_addr, 0);
        chk("rst mid dm_rdata", dm_rdata, 0);
        chk("rst mid if_rdata", if_rdata, 0);
        dm_req = 0;
        ref_dm = 0; ref_if = 0; ref_last = 3;
        n_ack = 0;
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ld_ack || dm_ack || if_ack) n_ack++;
        end
        chk("no ack after rst", n_ack, 0);
        chk("aborted write", mem[32'h408 >> 2], ref_mem[32'h408 >> 2]);
        do_txn(2, 0, 32'h408, 0);

        for (int k = 0; k < 40; k++) begin
            int own, sel;
            own = $urandom_range(1, 3);
            sel = $urandom_range(0, 7);
            a = 32'($urandom_range(0, 511)) << 2;
            if (sel == 6) a = a + 32'($urandom_range(1, 3));
            if (sel == 7) a = 32'h800 + (32'($urandom_range(0, 255)) << 2);
            do_txn(own, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
